// File: rtl/paramult_acc.sv
// paramult_acc: framed vector-by-scalar multiply-accumulate with saturating or wrapping lanes
module paramult_acc #(
  parameter int LANES  = 64,
  parameter int W      = 16,
  parameter int FRAC   = 0,
  parameter int SAT_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               usr_rst,
  input  logic               data_v,
  input  logic [LANES*W-1:0] in_veca_data,
  input  logic [W-1:0]       in_sig_data,
  input  logic [7:0]         acc_len,
  input  logic               out_rdy,
  output logic               need_data_w,
  output logic               reg_data_v_w,
  output logic [LANES*W-1:0] reg_data_w
);
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;
  localparam logic signed [2*W-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  state_t state, state_n;
  logic [7:0] cnt, len, len_in;
  logic p_v, accept;
  logic [LANES-1:0][W-1:0] prod_q, acc_q, prod_n, sum_n;
  function automatic logic signed [2*W-1:0] sx(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction
  function automatic logic [W-1:0] narrow(input logic signed [2*W-1:0] v);
    return (SAT_EN != 0 && v > MAXV) ? MAXV[W-1:0] :
           (SAT_EN != 0 && v < MINV) ? MINV[W-1:0] : v[W-1:0];
  endfunction
  assign need_data_w  = state == IDLE || state == ACC;
  assign reg_data_v_w = state == HOLD;
  assign reg_data_w   = acc_q;
  assign accept       = data_v && need_data_w;
  assign len_in       = acc_len == 8'd0 ? 8'd1 : acc_len;
  // per-lane narrowed product and narrowed running sum
  always_comb begin
    prod_n = '0;
    sum_n  = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_n[i] = narrow((sx(in_veca_data[i*W +: W]) * sx(in_sig_data)) >>> FRAC);
      sum_n[i]  = narrow(sx(acc_q[i]) + sx(prod_q[i]));
    end
  end
  // frame sequencing: collect len beats, let the last product land, hold until consumed
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (len_in == 8'd1 ? DRAIN : ACC) : IDLE;
      ACC:     state_n = accept && cnt + 8'd1 == len ? DRAIN : ACC;
      DRAIN:   state_n = p_v ? HOLD : DRAIN;
      default: state_n = out_rdy ? IDLE : HOLD;
    endcase
  end
  // state, beat counter, product stage and accumulators; usr_rst aborts the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      len    <= '0;
      p_v    <= 1'b0;
      prod_q <= '0;
      acc_q  <= '0;
    end else if (usr_rst) begin
      state <= IDLE;
      cnt   <= '0;
      p_v   <= 1'b0;
      acc_q <= '0;
    end else begin
      state <= state_n;
      p_v   <= accept;
      if (accept) begin
        prod_q <= prod_n;
        cnt    <= state == IDLE ? 8'd1 : cnt + 8'd1;
        if (state == IDLE) len <= len_in;
      end
      if (state == HOLD && out_rdy) acc_q <= '0;
      else if (p_v) acc_q <= sum_n;
    end
  end
endmodule
